// File: rtl/uart_types.sv
// rtl/uart_types.sv - shared UART state type and framing defaults
package uart_types;
  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} uart_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;
endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for rx_in plus history flop for edge detection
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_s,
  output logic fall
);
  logic meta;
  logic rx_q;

  // All flops reset high so a reset never looks like a falling edge on an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      meta <= rx_in;
      rx_s <= meta;
      rx_q <= rx_s;
    end
  end

  assign fall = rx_q & ~rx_s;
endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - oversampling 8N1 UART receiver with valid/ready byte output
module uart_rx_fsm
  import uart_types::uart_state_t;
  import uart_types::IDLE;
  import uart_types::START_BIT;
  import uart_types::STOP_BIT;
  import uart_types::UART_OVERSAMPLE;
  import uart_types::UART_DATA_BITS;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_t          state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_s;
  logic                 fall;
  logic                 accept;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_in (rx_in),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign accept  = rx_valid & rx_ready;
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      if (accept) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START_BIT;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end

        START_BIT: begin
          if (sample_tick) begin
            if (tick_cnt == TICK_HALF) begin
              // A high sample at mid-start means the edge was a glitch.
              state    <= rx_s ? IDLE : uart_types::DATA_BITS;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        uart_types::DATA_BITS: begin
          if (sample_tick) begin
            if (tick_cnt == TICK_LAST) begin
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              tick_cnt  <= '0;
              if (bit_cnt == BIT_LAST) begin
                state   <= STOP_BIT;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        STOP_BIT: begin
          if (sample_tick) begin
            if (tick_cnt == TICK_LAST) begin
              state    <= IDLE;
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (!rx_s) begin
                frame_err <= 1'b1;
              end else if (!rx_valid || accept) begin
                // Delivery overrides a same-cycle acceptance of the previous byte.
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end
endmodule
